nand_page_writer: RTL and testbench

NAND_PAGE_WRITER -- requirements
Module: nand_page_writer

---
 rtl/nand_page_writer.sv | 174 +++++++++++++++++
 tb/tb_nand_page_writer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_page_writer.sv
// nand_page_writer: programs one buffered page into an x16 NAND (0x80, address, data, 0x10, status poll).
// Define NAND_RB_TIMEOUT_EN to abandon WAIT_RB with fail=1 after RbTimeout cycles.
module nand_page_writer #(
  parameter int DataWidth = 16,
  parameter int PageDepth = 2048,
  parameter int RbTimeout = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [23:0]          row_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 cntrl_sel,
  output logic                 cntrl_re,
  input  logic [DataWidth-1:0] cntrl_out,
  input  logic                 buf_cntrl_status,
  output logic                 nand_ce_n,
  output logic                 nand_cle,
  output logic                 nand_ale,
  output logic                 nand_we_n,
  output logic                 nand_re_n,
  output logic [DataWidth-1:0] nand_io_out,
  output logic                 nand_io_oe,
  input  logic [DataWidth-1:0] nand_io_in,
  input  logic                 nand_rb_n
);
  localparam int DataCyc = 2 * PageDepth + 2;
  localparam int CntBig = DataCyc > RbTimeout ? DataCyc : RbTimeout;
  localparam int CntMax = CntBig > 15 ? CntBig : 15;
  localparam int CW = $clog2(CntMax + 1);
  localparam logic [CW-1:0] AddrLast = CW'(9);
  localparam logic [CW-1:0] DataLast = CW'(DataCyc - 1);
  localparam logic [CW-1:0] DataRd = CW'(2 * PageDepth);
  localparam logic [CW-1:0] TwbEnd = CW'(4);
`ifdef NAND_RB_TIMEOUT_EN
  localparam logic [CW-1:0] RbLast = CW'(RbTimeout - 1);
`endif

  typedef enum logic [3:0] {IDLE, CMD1, ADDR, DATA, CMD2, WAIT_RB, CMD_ST, READ_ST, DONE} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0] row_q, row_d;
  logic cmp_q, cmp_d, fail_q, fail_d;
  logic busy_q, busy_d, done_q, done_d, sel_q, sel_d, re_q, re_d;
  logic ce_n_q, ce_n_d, cle_q, cle_d, ale_q, ale_d, we_n_q, we_n_d, re_n_q, re_n_d, oe_q, oe_d;
  logic [DataWidth-1:0] io_q, io_d;
  logic [7:0] addr_byte, bus_byte;
  logic unused_io;

  assign unused_io = ^nand_io_in[DataWidth-1:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      row_q <= '0;
      cmp_q <= 1'b0;
      fail_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sel_q <= 1'b0;
      re_q <= 1'b0;
      ce_n_q <= 1'b1;
      cle_q <= 1'b0;
      ale_q <= 1'b0;
      we_n_q <= 1'b1;
      re_n_q <= 1'b1;
      oe_q <= 1'b0;
      io_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      cmp_q <= cmp_d;
      fail_q <= fail_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sel_q <= sel_d;
      re_q <= re_d;
      ce_n_q <= ce_n_d;
      cle_q <= cle_d;
      ale_q <= ale_d;
      we_n_q <= we_n_d;
      re_n_q <= re_n_d;
      oe_q <= oe_d;
      io_q <= io_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d = row_q;
    cmp_d = cmp_q;
    fail_d = fail_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CMD1;
        row_d = row_addr;
        cmp_d = 1'b0;
        fail_d = 1'b0;
      end
      CMD1: state_d = cnt_q[0] ? ADDR : CMD1;
      ADDR: state_d = cnt_q == AddrLast ? DATA : ADDR;
      DATA: begin
        cmp_d = cmp_q | buf_cntrl_status;
        if (cnt_q == DataLast) begin
          state_d = cmp_d ? CMD2 : DONE;
          fail_d = !cmp_d;
        end
      end
      CMD2: state_d = cnt_q[0] ? WAIT_RB : CMD2;
      WAIT_RB: begin
        if (cnt_q >= TwbEnd && nand_rb_n) state_d = CMD_ST;
`ifdef NAND_RB_TIMEOUT_EN
        else if (cnt_q == RbLast) begin
          state_d = DONE;
          fail_d = 1'b1;
        end
`endif
      end
      CMD_ST: state_d = cnt_q[0] ? READ_ST : CMD_ST;
      READ_ST: if (cnt_q[0]) begin
        state_d = DONE;
        fail_d = nand_io_in[0];
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
`ifndef NAND_RB_TIMEOUT_EN
    // only tWB needs counting here, so the counter parks at 4
    if (state_q == WAIT_RB && state_d == WAIT_RB && cnt_q == TwbEnd) cnt_d = cnt_q;
`endif
  end

  // outputs are decoded from the upcoming state so they line up with it once registered
  always_comb begin
    busy_d = state_d != IDLE;
    ce_n_d = state_d == IDLE;
    done_d = state_d == DONE;
    sel_d = state_d == DATA;
    re_d = sel_d && !cnt_d[0] && cnt_d < DataRd;
    cle_d = state_d inside {CMD1, CMD2, CMD_ST};
    ale_d = state_d == ADDR;
    oe_d = cle_d || ale_d || (sel_d && cnt_d >= CW'(2));
    we_n_d = !(oe_d && !cnt_d[0]);
    re_n_d = state_d != READ_ST;
    addr_byte = cnt_d[3:1] == 3'd2 ? row_q[7:0] :
                cnt_d[3:1] == 3'd3 ? row_q[15:8] :
                cnt_d[3:1] == 3'd4 ? row_q[23:16] : 8'h00;
    bus_byte = state_d == CMD1 ? 8'h80 :
               state_d == CMD2 ? 8'h10 :
               state_d == CMD_ST ? 8'h70 : addr_byte;
    io_d = (cle_d || ale_d) ? DataWidth'(bus_byte) :
           !sel_d ? '0 :
           (state_q == DATA && cnt_q[0]) ? cntrl_out : io_q;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;
  assign cntrl_sel = sel_q;
  assign cntrl_re = re_q;
  assign nand_ce_n = ce_n_q;
  assign nand_cle = cle_q;
  assign nand_ale = ale_q;
  assign nand_we_n = we_n_q;
  assign nand_re_n = re_n_q;
  assign nand_io_oe = oe_q;
  assign nand_io_out = io_q;
endmodule

// File: tb/tb_nand_page_writer.sv
// tb_nand_page_writer: randomized page programs checked against a transaction-level model of the bus.
module tb_nand_page_writer;
  localparam int PD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [23:0] row_addr = '0;
  logic busy, done, fail, cntrl_sel, cntrl_re, buf_cntrl_status;
  logic [15:0] cntrl_out = '0;
  logic nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_re_n, nand_io_oe;
  logic [15:0] nand_io_out, nand_io_in;
  logic nand_rb_n = 1'b1;

  always #5 clk = ~clk;

  nand_page_writer #(.DataWidth(16), .PageDepth(PD), .RbTimeout(100)) dut (
    .clk(clk), .rst(rst), .start(start), .row_addr(row_addr),
    .busy(busy), .done(done), .fail(fail),
    .cntrl_sel(cntrl_sel), .cntrl_re(cntrl_re), .cntrl_out(cntrl_out),
    .buf_cntrl_status(buf_cntrl_status),
    .nand_ce_n(nand_ce_n), .nand_cle(nand_cle), .nand_ale(nand_ale),
    .nand_we_n(nand_we_n), .nand_re_n(nand_re_n),
    .nand_io_out(nand_io_out), .nand_io_oe(nand_io_oe),
    .nand_io_in(nand_io_in), .nand_rb_n(nand_rb_n)
  );

  int checks = 0, errors = 0, cyc = 0, nw = 0, nre = 0, rb_cnt = 0, rb_delay = 0;
  int t10 = 0, done_cyc = 0, ptr = 0;
  bit mon_en = 0, done_seen = 0, exp_fail = 0, last_fail = 0, force0 = 0, st_bit = 0, rb_stuck = 0;
  logic [14:0] io_hi = '0;
  logic [15:0] mem [PD];
  logic [17:0] exp_q [$];
  logic [17:0] wlog [64];
  logic [17:0] bus, e_bus, prev_bus = '0;
  logic prev_we_lo = 1'b0, prev_done = 1'b0;

  // page buffer: read pointer rewinds whenever sel drops
  always @(posedge clk) begin
    if (!cntrl_sel) ptr <= 0;
    else if (cntrl_re) begin
      cntrl_out <= mem[ptr[2:0]];
      ptr <= ptr + 1;
    end
  end
  assign buf_cntrl_status = !force0 && ptr == PD;
  assign nand_io_in = nand_re_n ? 16'hFFFF : {io_hi, st_bit};

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk(busy === 1'b0, "rst_busy", int'(busy), 0);
    chk(done === 1'b0, "rst_done", int'(done), 0);
    chk(fail === 1'b0, "rst_fail", int'(fail), 0);
    chk(cntrl_sel === 1'b0, "rst_sel", int'(cntrl_sel), 0);
    chk(cntrl_re === 1'b0, "rst_re", int'(cntrl_re), 0);
    chk(nand_ce_n === 1'b1, "rst_ce_n", int'(nand_ce_n), 1);
    chk(nand_we_n === 1'b1, "rst_we_n", int'(nand_we_n), 1);
    chk(nand_re_n === 1'b1, "rst_re_n", int'(nand_re_n), 1);
    chk(nand_cle === 1'b0, "rst_cle", int'(nand_cle), 0);
    chk(nand_ale === 1'b0, "rst_ale", int'(nand_ale), 0);
    chk(nand_io_oe === 1'b0, "rst_oe", int'(nand_io_oe), 0);
    chk(nand_io_out === 16'h0, "rst_io", int'(nand_io_out), 0);
  endtask

  // bus monitor: every write must match the head of the expected transaction queue
  always @(negedge clk) begin
    cyc++;
    if (rb_cnt > 0) rb_cnt--;
    nand_rb_n = rb_cnt == 0 && !rb_stuck;
    bus = {nand_cle, nand_ale, nand_io_out};
    if (mon_en) begin
      chk(nand_ce_n == !busy, "ce_vs_busy", int'(nand_ce_n), int'(!busy));
      if (prev_we_lo)
        chk(nand_we_n && nand_io_oe && bus == prev_bus, "write_hold", int'({nand_we_n, bus}), int'({1'b1, prev_bus}));
      if (!nand_we_n) begin
        chk(nand_io_oe, "write_oe", int'(nand_io_oe), 1);
        if (nw < 64) wlog[nw] = bus;
        nw++;
        chk(exp_q.size() != 0, "write_expected", int'(bus), 0);
        if (exp_q.size() != 0) begin
          e_bus = exp_q.pop_front();
          chk(bus == e_bus, "bus_write", int'(bus), int'(e_bus));
        end
        if (bus == 18'h20010) begin
          rb_cnt = rb_delay + 2;
          t10 = cyc;
        end
      end
      if (cntrl_re) begin
        nre++;
        chk(cntrl_sel, "re_outside_data", int'(cntrl_sel), 1);
      end
      if (!nand_re_n) chk(!nand_io_oe, "read_oe_off", int'(nand_io_oe), 0);
      if (prev_done) chk(!done && !busy, "done_one_cycle", int'({done, busy}), 0);
      if (done) begin
        done_seen = 1;
        done_cyc = cyc;
        chk(fail == exp_fail, "fail_at_done", int'(fail), int'(exp_fail));
        chk(exp_q.size() == 0, "writes_missing", exp_q.size(), 0);
        chk(nre == PD, "re_pulses", nre, PD);
      end
    end
    prev_we_lo = mon_en && !nand_we_n;
    prev_bus = bus;
    prev_done = mon_en && done;
  end

  task automatic run_op(input logic [23:0] row, input bit complete, input bit st, input int rbd,
                        input bit tmo, input bit seq_words, input bit do_reset);
    for (int i = 0; i < PD; i++) mem[i] = seq_words ? 16'hA000 + 16'(i) : 16'($urandom);
    exp_q.delete();
    exp_q.push_back({2'b10, 16'h0080});
    exp_q.push_back({2'b01, 16'h0000});
    exp_q.push_back({2'b01, 16'h0000});
    exp_q.push_back({2'b01, 8'h00, row[7:0]});
    exp_q.push_back({2'b01, 8'h00, row[15:8]});
    exp_q.push_back({2'b01, 8'h00, row[23:16]});
    for (int i = 0; i < PD; i++) exp_q.push_back({2'b00, mem[i]});
    if (complete) begin
      exp_q.push_back({2'b10, 16'h0010});
      if (!tmo) exp_q.push_back({2'b10, 16'h0070});
    end
    exp_fail = !complete || tmo || st;
    force0 = !complete;
    st_bit = st;
    rb_delay = rbd;
    rb_stuck = tmo;
    io_hi = 15'($urandom);
    nw = 0;
    nre = 0;
    done_seen = 0;
    @(negedge clk);
    chk(fail == last_fail, "fail_held", int'(fail), int'(last_fail));
    mon_en = 1;
    start = 1;
    row_addr = row;
    @(negedge clk);
    start = 0;
    row_addr = 24'($urandom);
    chk(busy && !fail, "start_accept", int'({busy, fail}), 2);
    if (do_reset) begin
      for (int i = 0; i < 40 && !cntrl_sel; i++) @(negedge clk);
      chk(cntrl_sel, "reach_data", int'(cntrl_sel), 1);
      repeat (5) @(negedge clk);
      mon_en = 0;
      rst = 1;
      @(negedge clk);
      chk_reset();
      rst = 0;
      last_fail = 0;
      return;
    end
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      @(negedge clk);
      start = (i == 20);
    end
    start = 0;
    chk(done_seen, "done_timeout", int'(done_seen), 1);
    last_fail = exp_fail;
    @(negedge clk);
    mon_en = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 0;
    run_op(24'h123456, 1, 0, 5, 0, 1, 0);
    chk(nw == 16, "seq_write_count", nw, 16);
    chk(wlog[0] == 18'h20080, "seq_cmd80", int'(wlog[0]), 'h20080);
    chk(wlog[3] == 18'h10056, "seq_row0", int'(wlog[3]), 'h10056);
    chk(wlog[4] == 18'h10034, "seq_row1", int'(wlog[4]), 'h10034);
    chk(wlog[5] == 18'h10012, "seq_row2", int'(wlog[5]), 'h10012);
    chk(wlog[6] == 18'h0A000, "seq_word0", int'(wlog[6]), 'h0A000);
    chk(wlog[13] == 18'h0A007, "seq_word7", int'(wlog[13]), 'h0A007);
    chk(wlog[14] == 18'h20010, "seq_cmd10", int'(wlog[14]), 'h20010);
    chk(wlog[15] == 18'h20070, "seq_cmd70", int'(wlog[15]), 'h20070);
    chk(nre == 8 && fail == 1'b0, "seq_re_fail", nre, 8);
    run_op(24'($urandom), 1, 1, 8, 0, 0, 0);
    chk(fail == 1'b1, "status_fail", int'(fail), 1);
    run_op(24'($urandom), 0, 0, 0, 0, 0, 0);
    chk(nw == 14 && fail == 1'b1, "incomplete_no_10", nw, 14);
    run_op(24'($urandom), 1, 0, 3, 0, 0, 1);
    repeat (2) @(negedge clk);
    run_op(24'h00ABCD, 1, 0, 10, 0, 1, 0);
    chk(nw == 16 && fail == 1'b0, "after_reset_ok", nw, 16);
`ifdef NAND_RB_TIMEOUT_EN
    run_op(24'($urandom), 1, 0, 0, 1, 0, 0);
    chk(done_cyc - t10 == 102, "rb_timeout_cycles", done_cyc - t10, 102);
    chk(nw == 15 && fail == 1'b1, "rb_timeout_no_70", nw, 15);
    rb_stuck = 0;
`endif
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(24'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 30), 0, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
